// File: rtl/uart_pkg.sv
// Shared UART definitions: frame FSM states and parity-mode encodings.
// Used by both the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  typedef logic [1:0] par_mode_t;

  localparam par_mode_t PAR_NONE = 2'b00;
  localparam par_mode_t PAR_EVEN = 2'b01;
  localparam par_mode_t PAR_ODD  = 2'b10;

  // True for the two encodings that add a parity bit; 2'b11 behaves as none.
  function automatic logic par_is_active(input par_mode_t mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

  // Parity bit for up to 9 data bits (narrower payloads are zero-extended,
  // which leaves the XOR unchanged).
  function automatic logic par_bit_of(input logic [8:0] data, input par_mode_t mode);
    return (^data) ^ (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_tx_frame_if.sv
// Byte-producer handshake into the UART transmitter: payload, valid, ready.
// A transfer happens on a clk edge where din_vld && rdy.
interface uart_tx_frame_if #(
  parameter int DATA_BITS = 8
);

  logic [DATA_BITS-1:0] din;
  logic                 din_vld;
  logic                 rdy;

  modport master (output din, output din_vld, input rdy);
  modport slave  (input din, input din_vld, output rdy);

endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous show-ahead FIFO feeding the transmitter. rd_data always shows
// the oldest entry; a push while full is dropped even if a pop happens in the
// same cycle, so the producer must respect full.
module uart_tx_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [W-1:0]             wr_data,
  input  logic                     rd_en,
  output logic [W-1:0]             rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] count;
  logic          push;
  logic          pop;

  assign full    = (count == LW'(DEPTH));
  assign empty   = (count == '0);
  assign level   = count;
  assign push    = wr_en && !full;
  assign pop     = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  // Storage write.
  // NOTE: the data array has no reset; occupancy is tracked by count, so stale
  // entries are never observed and the array can map onto plain RAM/flops.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // Pointers and occupancy; depth is a power of two so pointers wrap freely.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter with input FIFO. Frames are start, DATA_BITS data bits
// LSB first, optional parity, then one or two stop bits; each bit lasts BPS
// clocks. Format (par_mode, stop2) is latched when a frame starts, and a
// queued byte starts immediately after the last stop bit with no idle gap.
// Build option: define UART_TX_PARITY_EN to build the parity logic and honour
// par_mode; otherwise par_mode is ignored and every frame has no parity.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int BPS        = 217,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  uart_tx_frame_if.slave                s_if,
  input  logic [1:0]                    par_mode,
  input  logic                          stop2,
  output logic                          dout,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int CYC_W = $clog2(BPS);
  localparam int BIT_W = $clog2(DATA_BITS);

  tx_state_t            state_q, state_d;
  logic [CYC_W-1:0]     cyc_q, cyc_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 dout_q, dout_d;
  logic                 stop2_q, stop2_d;

  logic                 fifo_pop;
  logic [DATA_BITS-1:0] fifo_data;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 bit_end;
  logic                 launch;
  logic                 frame_has_par;
  logic                 frame_par_bit;

  uart_tx_fifo #(
    .W     (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (s_if.din_vld),
    .wr_data (s_if.din),
    .rd_en   (fifo_pop),
    .rd_data (fifo_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (level)
  );

`ifdef UART_TX_PARITY_EN
  logic par_en_q, par_en_d;
  logic par_bit_q, par_bit_d;

  assign frame_has_par = par_en_q;
  assign frame_par_bit = par_bit_q;

  // Parity format and bit are captured with the payload at frame start.
  always_ff @(posedge clk) begin
    if (rst) begin
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
    end else begin
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
    end
  end

  // Next parity latch values: reload only when a frame launches.
  always_comb begin
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    if (launch) begin
      par_en_d  = par_is_active(par_mode);
      par_bit_d = par_bit_of(9'(fifo_data), par_mode);
    end
  end
`else
  logic par_mode_unused;

  assign par_mode_unused = ^par_mode;
  assign frame_has_par   = 1'b0;
  assign frame_par_bit   = 1'b0;
`endif

  assign s_if.rdy = !fifo_full;
  assign dout     = dout_q;
  assign busy     = (state_q != IDLE) || (level != '0);
  assign bit_end  = (cyc_q == CYC_W'(BPS - 1));

  // Frame state register; dout is registered so the line never glitches.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cyc_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      dout_q  <= 1'b1;
      stop2_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      dout_q  <= dout_d;
      stop2_q <= stop2_d;
    end
  end

  // Next-state and next-line logic; launch covers both IDLE start and the
  // back-to-back start at the end of the last stop bit.
  // NOTE: every signal assigned here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    cyc_d    = cyc_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    dout_d   = dout_q;
    stop2_d  = stop2_q;
    fifo_pop = 1'b0;
    launch   = 1'b0;

    if (state_q != IDLE) cyc_d = bit_end ? '0 : cyc_q + CYC_W'(1);

    case (state_q)
      IDLE: begin
        dout_d = 1'b1;
        launch = !fifo_empty;
      end

      START: begin
        if (bit_end) begin
          state_d = DATA;
          bit_d   = '0;
          dout_d  = shift_q[0];
          shift_d = shift_q >> 1;
        end
      end

      DATA: begin
        if (bit_end) begin
          if (bit_q == BIT_W'(DATA_BITS - 1)) begin
            if (frame_has_par) begin
              state_d = PARITY;
              dout_d  = frame_par_bit;
            end else begin
              state_d = STOP;
              bit_d   = '0;
              dout_d  = 1'b1;
            end
          end else begin
            bit_d   = bit_q + BIT_W'(1);
            dout_d  = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          bit_d   = '0;
          dout_d  = 1'b1;
        end
      end
`endif

      STOP: begin
        if (bit_end) begin
          if (stop2_q && (bit_q == '0)) begin
            bit_d  = BIT_W'(1);
            dout_d = 1'b1;
          end else if (!fifo_empty) begin
            launch = 1'b1;
          end else begin
            state_d = IDLE;
            dout_d  = 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
        dout_d  = 1'b1;
      end
    endcase

    if (launch) begin
      fifo_pop = 1'b1;
      shift_d  = fifo_data;
      stop2_d  = stop2;
      state_d  = START;
      cyc_d    = '0;
      bit_d    = '0;
      dout_d   = 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Testbench for uart_tx_frame (BPS=4, DATA_BITS=8, FIFO_DEPTH=4). A queue
// model expands each started frame into its per-cycle line values and tracks
// FIFO occupancy; every cycle the DUT outputs are compared with it. Directed
// scenarios add literal expectations for bit patterns and frame lengths.
module tb_uart_tx_frame;

  localparam int BPS   = 4;
  localparam int DB    = 8;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam bit PAR_BUILT = 1'b1;
`else
  localparam bit PAR_BUILT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] par_mode = 2'b00;
  logic       stop2 = 1'b0;
  logic       dout;
  logic       busy;
  logic [2:0] level;

  uart_tx_frame_if #(.DATA_BITS(DB)) tx_if ();

  uart_tx_frame #(
    .BPS        (BPS),
    .DATA_BITS  (DB),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .s_if     (tx_if),
    .par_mode (par_mode),
    .stop2    (stop2),
    .dout     (dout),
    .busy     (busy),
    .level    (level)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] mq[$];     // bytes accepted but not yet started
  bit         wave[$];   // line value for each remaining cycle of the frame
  bit         exp_dout  = 1'b1;
  bit         exp_rdy   = 1'b1;
  bit         exp_busy  = 1'b0;
  int         exp_level = 0;
  bit         chk_en    = 1'b0;
  bit         m_acc;
  logic [7:0] m_din;
  logic [7:0] m_byte;
  bit         m_par_on;
  bit         m_pbit;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      wave.delete();
    end else begin
      m_acc = tx_if.din_vld && (mq.size() < DEPTH);
      m_din = tx_if.din;
      if (wave.size() > 0) void'(wave.pop_front());
      if (wave.size() == 0 && mq.size() > 0) begin
        m_byte   = mq.pop_front();
        m_par_on = PAR_BUILT && (par_mode == 2'b01 || par_mode == 2'b10);
        m_pbit   = (^m_byte) ^ (par_mode == 2'b10);
        for (int c = 0; c < BPS; c++) wave.push_back(1'b0);
        for (int i = 0; i < DB; i++)
          for (int c = 0; c < BPS; c++) wave.push_back(m_byte[i]);
        if (m_par_on)
          for (int c = 0; c < BPS; c++) wave.push_back(m_pbit);
        for (int c = 0; c < BPS * (stop2 ? 2 : 1); c++) wave.push_back(1'b1);
      end
      if (m_acc) mq.push_back(m_din);
    end
    exp_dout  = (wave.size() > 0) ? wave[0] : 1'b1;
    exp_level = mq.size();
    exp_rdy   = (mq.size() < DEPTH);
    exp_busy  = (wave.size() > 0) || (mq.size() > 0);
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("dout",  int'(dout),      int'(exp_dout));
      check("rdy",   int'(tx_if.rdy), int'(exp_rdy));
      check("busy",  int'(busy),      int'(exp_busy));
      check("level", int'(level),     exp_level);
    end
  end

  // ---------------- stimulus helpers ----------------
  bit cap[0:399];

  // Present one byte; returns just after the accepting edge with valid low.
  task automatic send(input logic [7:0] d, output int waits);
    waits = 0;
    @(negedge clk);
    tx_if.din     = d;
    tx_if.din_vld = 1'b1;
    while (!tx_if.rdy && waits < 2000) begin
      waits++;
      @(negedge clk);
    end
    if (waits >= 2000) begin
      check("send_timeout", 1, 0);
      tx_if.din_vld = 1'b0;
    end else begin
      @(posedge clk);
      #1 tx_if.din_vld = 1'b0;
    end
  endtask

  // Record dout every cycle while busy, starting at the next negedge.
  task automatic capture(output int len);
    len = 0;
    @(negedge clk);
    while (busy && len < 400) begin
      cap[len] = dout;
      len++;
      @(negedge clk);
    end
    if (len >= 400) check("capture_timeout", 1, 0);
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 2000) begin
      n++;
      @(negedge clk);
    end
    if (n >= 2000) check("idle_timeout", 1, 0);
  endtask

  // ---------------- directed scenarios ----------------
  int w, len;
  int a5_bits[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};

  initial begin
    tx_if.din     = '0;
    tx_if.din_vld = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    check("reset_dout",  int'(dout), 1);
    check("reset_rdy",   int'(tx_if.rdy), 1);
    check("reset_busy",  int'(busy), 0);
    check("reset_level", int'(level), 0);
    rst = 1'b0;

    // 8N1, 0xA5: line held high one cycle after acceptance, falls next.
    send(8'hA5, w);
    @(negedge clk);
    check("a5_latency_high", int'(dout), 1);
    capture(len);
    check("a5_fall", int'(cap[0]), 0);
    for (int k = 0; k < 10; k++)
      check("a5_bit", int'(cap[k * BPS + BPS / 2]), a5_bits[k]);
    check("a5_len", len, 40);

    // Even parity on 0x07 -> parity bit 1.
    par_mode = 2'b01;
    send(8'h07, w);
    @(negedge clk);
    capture(len);
    check("even_len", len, PAR_BUILT ? 44 : 40);
    check("even_bit9", int'(cap[9 * BPS + BPS / 2]), 1);

    // Odd parity on 0x07 -> parity bit 0.
    par_mode = 2'b10;
    send(8'h07, w);
    @(negedge clk);
    capture(len);
    check("odd_len", len, PAR_BUILT ? 44 : 40);
    check("odd_bit9", int'(cap[9 * BPS + BPS / 2]), PAR_BUILT ? 0 : 1);
    wait_idle();

    // Two stop bits, 0x00 then 0xFF back-to-back.
    par_mode = 2'b00;
    stop2    = 1'b1;
    send(8'h00, w);
    send(8'hFF, w);
    capture(len);
    check("s2_len", len, 88);
    check("s2_last_stop", int'(cap[43]), 1);
    check("s2_second_start", int'(cap[44]), 0);
    check("s2_second_d0", int'(cap[44 + BPS + BPS / 2]), 1);

    // Fill the FIFO while a frame is in flight; the sixth byte must wait.
    stop2 = 1'b0;
    send(8'h11, w);
    repeat (3) @(negedge clk);
    send(8'h22, w);
    send(8'h33, w);
    send(8'h44, w);
    send(8'h55, w);
    check("fill_level", int'(level), 4);
    check("fill_rdy", int'(tx_if.rdy), 0);
    send(8'h66, w);
    check("fill_blocked", int'(w > 0), 1);
    wait_idle();

    // Format change mid-frame only affects the following frame.
    send(8'h3C, w);
    @(negedge clk);
    fork
      capture(len);
      begin
        repeat (6) @(negedge clk);
        par_mode = 2'b10;
        stop2    = 1'b1;
      end
    join
    check("tog_first_len", len, 40);
    send(8'h3C, w);
    @(negedge clk);
    capture(len);
    check("tog_second_len", len, PAR_BUILT ? 48 : 44);
    check("tog_second_bit9", int'(cap[9 * BPS + BPS / 2]), 1);
    par_mode = 2'b00;
    stop2    = 1'b0;

    // Reset mid-DATA with two bytes queued.
    send(8'hAA, w);
    send(8'hBB, w);
    send(8'hCC, w);
    repeat (10) @(negedge clk);
    check("rst_queued", int'(level), 2);
    rst = 1'b1;
    @(negedge clk);
    check("rst_dout",  int'(dout), 1);
    check("rst_level", int'(level), 0);
    check("rst_busy",  int'(busy), 0);
    check("rst_rdy",   int'(tx_if.rdy), 1);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    check("rst_no_resume", int'(busy), 0);

    @(negedge clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
